// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side streaming adapter: buffer state
// encodings, counter width and the occupancy bookkeeping helper.
package fifo_rd_stream_pkg;

    // Width of the completed-transfer counter.
    localparam int WORDS_OUT_W = 16;

    // Output buffer depth, sized to compare against committed_words().
    localparam logic [2:0] BUF_DEPTH = 3'd2;

    // Output buffer fill state; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // Words that will be buffered after this edge if no new pop is issued:
    // what is held now, plus the word in flight, minus the word leaving.
    function automatic logic [2:0] committed_words(input logic [1:0] occ,
                                                   input logic       inflight,
                                                   input logic       pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready stream bundle used by fifo_rd_stream.
// master = the adapter, slave = the FIFO model and the stream sink.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer. head_r is always the oldest word and drives the
// stream directly, so m_data comes straight from a register. A capture and a
// pop in the same cycle keep the fill level and preserve word order.
module fifo_rd_skid
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  flush,
    input  logic                  capture,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output buf_state_e            state,
    output logic [DATA_WIDTH-1:0] head
);

    buf_state_e            state_r;
    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] tail_r;

    // Buffer fill state and word storage; flush empties without touching data.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_r <= BUF_EMPTY;
            head_r  <= {DATA_WIDTH{1'b0}};
            tail_r  <= {DATA_WIDTH{1'b0}};
        end else if (flush) begin
            state_r <= BUF_EMPTY;
        end else begin
            case (state_r)
                BUF_EMPTY: begin
                    // Nothing is shown while empty, so only a capture matters.
                    if (capture) begin
                        head_r  <= din;
                        state_r <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (capture && pop) begin
                        head_r <= din;
                    end else if (capture) begin
                        tail_r  <= din;
                        state_r <= BUF_TWO;
                    end else if (pop) begin
                        state_r <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    // A capture without a pop cannot occur here: the pop
                    // request logic never over-commits the buffer.
                    if (pop) begin
                        head_r <= tail_r;
                        if (capture) begin
                            tail_r <= din;
                        end else begin
                            state_r <= BUF_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= BUF_EMPTY;
                end
            endcase
        end
    end

    assign state = state_r;
    assign head  = head_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a first-word-not-fall-through FIFO read port (data one cycle after
// the pop) into a valid/ready stream. Pops are issued only when the 2-entry
// buffer is guaranteed room for the returning word, which gives full
// throughput with a registered stream output.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst_n,
    input  logic                   flush,
    fifo_rd_stream_if.master       bus,
    output logic [1:0]             occupancy,
    output logic [WORDS_OUT_W-1:0] words_out
);

    buf_state_e             buf_state_s;
    logic [DATA_WIDTH-1:0]  head_s;
    logic                   m_valid_s;
    logic                   pop_s;
    logic                   capture_s;
    logic                   fifo_rd_en_s;
    logic [2:0]             committed_s;
    logic                   inflight_r;
    logic [WORDS_OUT_W-1:0] words_out_r;

    assign m_valid_s = (buf_state_s != BUF_EMPTY);
    assign pop_s     = m_valid_s && bus.m_ready;
    // The word popped last cycle lands now; during flush the buffer drops it.
    assign capture_s = inflight_r;

    // Pop request: only out of reset, with data available, not flushing, and
    // with room left for the word after accounting for in-flight and leaving.
    always_comb begin
        committed_s = committed_words(buf_state_s, inflight_r, pop_s);
        if (rd_rst_n && !bus.fifo_empty && !flush && (committed_s < BUF_DEPTH)) begin
            fifo_rd_en_s = 1'b1;
        end else begin
            fifo_rd_en_s = 1'b0;
        end
    end

    // In-flight flag: a pop issued this cycle returns data next cycle.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            inflight_r <= 1'b0;
        end else if (flush) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= fifo_rd_en_s;
        end
    end

    // Completed-transfer counter; a pop coinciding with flush is not counted.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            words_out_r <= {WORDS_OUT_W{1'b0}};
        end else if (pop_s && !flush) begin
            words_out_r <= words_out_r + {{(WORDS_OUT_W-1){1'b0}}, 1'b1};
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .flush    (flush),
        .capture  (capture_s),
        .pop      (pop_s),
        .din      (bus.fifo_dout),
        .state    (buf_state_s),
        .head     (head_s)
    );

    assign bus.fifo_rd_en = fifo_rd_en_s;
    assign bus.m_valid    = m_valid_s;
    assign bus.m_data     = head_s;
    assign occupancy      = buf_state_s;
    assign words_out      = words_out_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, every
// word leaving the FIFO becomes an expected stream word, and a negedge
// monitor pops and compares whenever a transfer happens. Flush and reset
// drop every word that has left the FIFO but not yet been delivered.
module tb_fifo_rd_stream;

    localparam int DW = 8;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        flush;
    logic [1:0]  occupancy;
    logic [15:0] words_out;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [15:0]   wo_model;

    logic          prev_valid;
    logic          prev_ready;
    logic          prev_flush;
    logic [DW-1:0] prev_data;
    logic          inflight_m;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .words_out (words_out)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: a pop seen before the edge delivers its word after the edge.
    initial begin
        logic r;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        forever begin
            @(negedge rd_clk);
            r = bus.fifo_rd_en;
            @(posedge rd_clk);
            #1;
            if (r) begin
                check("pop_nonempty", (fifo_q.size() != 0), 1);
                if (fifo_q.size() != 0) begin
                    bus.fifo_dout = fifo_q.pop_front();
                    exp_q.push_back(bus.fifo_dout);
                end
            end
            #1;
            bus.fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic pop;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_flush = 1'b0;
        prev_data  = '0;
        inflight_m = 1'b0;
        wo_model   = 16'd0;
        forever begin
            @(negedge rd_clk);
            if (!rd_rst_n) begin
                exp_q.delete();
                wo_model   = 16'd0;
                prev_valid = 1'b0;
                inflight_m = 1'b0;
                check("rst_valid", bus.m_valid, 0);
                check("rst_rd_en", bus.fifo_rd_en, 0);
                check("rst_occ", occupancy, 0);
                check("rst_words_out", words_out, 0);
            end else begin
                pop = bus.m_valid && bus.m_ready;
                check("words_out", words_out, wo_model);
                check("valid_vs_occ", bus.m_valid, (occupancy != 2'd0));
                check("no_overflow", (inflight_m && occupancy == 2'd2 && !pop && !flush), 0);
                if (prev_valid && !prev_ready && !prev_flush) begin
                    check("hold_valid", bus.m_valid, 1);
                    check("hold_data", bus.m_data, prev_data);
                end
                if (pop && !flush) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", bus.m_data, 32'hFFFF_FFFF);
                    end else begin
                        check("stream_data", bus.m_data, exp_q.pop_front());
                    end
                    wo_model = wo_model + 16'd1;
                end
                if (flush) begin
                    exp_q.delete();
                end
                inflight_m = bus.fifo_rd_en;
                prev_valid = bus.m_valid;
                prev_ready = bus.m_ready;
                prev_flush = flush;
                prev_data  = bus.m_data;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic drain(input int limit, input string name);
        int k;
        k = 0;
        @(negedge rd_clk);
        #1;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || occupancy != 2'd0) && k < limit) begin
            @(negedge rd_clk);
            #1;
            k++;
        end
        check(name, (k < limit), 1);
        @(posedge rd_clk);
        #1;
    endtask

    initial begin
        int cnt;
        int first_c;
        int last_c;
        int k;
        int rem;
        rd_rst_n    = 1'b0;
        flush       = 1'b0;
        bus.m_ready = 1'b0;
        step(3);
        rd_rst_n = 1'b1;

        // Single word: empty falls in cycle 10, shown in cycle 12.
        bus.m_ready = 1'b1;
        step(10);
        fifo_q.push_back(8'hA5);
        @(negedge rd_clk);
        check("sw_rd_en_c10", bus.fifo_rd_en, 1);
        check("sw_valid_c10", bus.m_valid, 0);
        @(negedge rd_clk);
        check("sw_rd_en_c11", bus.fifo_rd_en, 0);
        check("sw_valid_c11", bus.m_valid, 0);
        @(negedge rd_clk);
        check("sw_valid_c12", bus.m_valid, 1);
        check("sw_data_c12", bus.m_data, 8'hA5);
        @(negedge rd_clk);
        check("sw_words_out", words_out, 1);
        check("sw_rd_en_c13", bus.fifo_rd_en, 0);
        step(1);

        // Streaming: 8 words back to back.
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        cnt = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge rd_clk);
            if (bus.m_valid && bus.m_ready) begin
                if (cnt == 0) first_c = c;
                else check("stream_gap", c, last_c + 1);
                last_c = c;
                cnt++;
            end
        end
        check("stream_count", cnt, 8);
        check("stream_span", last_c - first_c, 7);
        check("stream_words_out", words_out, 9);
        step(1);

        // Backpressure: buffer fills to two and holds the head word.
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) fifo_q.push_back(8'(i));
        repeat (6) @(negedge rd_clk);
        check("bp_occ", occupancy, 2);
        check("bp_rd_en", bus.fifo_rd_en, 0);
        check("bp_valid", bus.m_valid, 1);
        check("bp_data", bus.m_data, 8'h01);
        step(1);
        bus.m_ready = 1'b1;
        drain(50, "bp_drain_timeout");
        check("bp_words_out", words_out, 14);

        // Flush with one word buffered and 0x33 in flight.
        bus.m_ready = 1'b0;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        fifo_q.push_back(8'h44);
        repeat (5) @(negedge rd_clk);
        check("fl_occ_full", occupancy, 2);
        step(1);
        bus.m_ready = 1'b1;
        @(negedge rd_clk);
        check("fl_pop_33", bus.fifo_rd_en, 1);
        check("fl_head_11", bus.m_data, 8'h11);
        step(1);
        bus.m_ready = 1'b0;
        flush = 1'b1;
        @(negedge rd_clk);
        check("fl_occ_during", occupancy, 1);
        check("fl_rd_en_during", bus.fifo_rd_en, 0);
        step(1);
        flush = 1'b0;
        @(negedge rd_clk);
        check("fl_occ_after", occupancy, 0);
        check("fl_valid_after", bus.m_valid, 0);
        step(1);
        bus.m_ready = 1'b1;
        k = 0;
        @(negedge rd_clk);
        while (!bus.m_valid && k < 10) begin
            @(negedge rd_clk);
            k++;
        end
        check("fl_next_timeout", (k < 10), 1);
        check("fl_next_44", bus.m_data, 8'h44);
        drain(50, "fl_drain_timeout");
        check("fl_words_out", words_out, 16);

        // Reset mid-stream with one word buffered.
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h60 + i));
        repeat (4) @(negedge rd_clk);
        check("rs_occ_before", occupancy, 1);
        @(posedge rd_clk);
        #3;
        rd_rst_n = 1'b0;
        #1;
        check("rs_valid_now", bus.m_valid, 0);
        check("rs_words_out_now", words_out, 0);
        check("rs_rd_en_now", bus.fifo_rd_en, 0);
        check("rs_occ_now", occupancy, 0);
        repeat (3) @(negedge rd_clk);
        check("rs_fifo_not_empty", (fifo_q.size() != 0), 1);
        step(1);
        rd_rst_n = 1'b1;
        rem = fifo_q.size();
        drain(50, "rs_drain_timeout");
        check("rs_words_out_after", words_out, rem);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 20) fifo_q.push_back(8'($urandom));
            bus.m_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            if (flush) bus.m_ready = 1'b0;
            step(1);
        end
        flush = 1'b0;
        bus.m_ready = 1'b1;
        drain(100, "rand_drain_timeout");

        // Counter wrap after 65535 + 1 transfers.
        rd_rst_n = 1'b0;
        step(2);
        rd_rst_n = 1'b1;
        for (int i = 0; i < 65535; i++) fifo_q.push_back(8'($urandom));
        drain(70000, "wrap_drain_timeout");
        check("wrap_ffff", words_out, 16'hFFFF);
        fifo_q.push_back(8'h5A);
        drain(20, "wrap_last_timeout");
        check("wrap_zero", words_out, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
